// File: rtl/dcache_arb2.sv
// dcache_arb2: two-client round-robin arbiter for the dcache request port,
// with an in-order owner tag FIFO that routes responses back to the issuer.
module dcache_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4,
    parameter int TAG_PTR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_valid,
    output logic                  c0_ready,
    input  logic                  c0_wr,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    output logic                  c0_rvalid,
    output logic [DATA_WIDTH-1:0] c0_rdata,
    input  logic                  c1_valid,
    output logic                  c1_ready,
    input  logic                  c1_wr,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    output logic                  c1_rvalid,
    output logic [DATA_WIDTH-1:0] c1_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_wr,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  err
);
    typedef enum logic {IDLE, LOCK} state_t;

    state_t                 r_state, w_next;
    logic                   r_owner, r_last, r_err;
    logic [TAG_DEPTH-1:0]   r_tags;
    logic [TAG_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [TAG_PTR_W:0]     r_count;
    logic                   w_win, w_sel, w_mv, w_can, w_push, w_pop, w_head;

    assign w_can  = r_count != (TAG_PTR_W+1)'(TAG_DEPTH);
    // Tie goes to whichever client did not win last; a lone requester always wins.
    assign w_win  = (c0_valid & c1_valid) ? ~r_last : c1_valid;
    assign w_push = w_mv & m_ready;
    assign w_pop  = m_rvalid & (r_count != '0);
    assign w_head = r_tags[r_rd_ptr];

    always_comb begin
        w_next = r_state;
        w_sel  = w_win;
        w_mv   = 1'b0;
        if (r_state == IDLE) begin
            w_mv = ~rst & w_can & (c0_valid | c1_valid);
            if (w_mv & ~m_ready) w_next = LOCK;
        end else begin
            w_sel = r_owner;
            w_mv  = ~rst;
            if (m_ready) w_next = IDLE;
        end
    end

    assign m_valid   = w_mv;
    assign m_wr      = w_sel ? c1_wr    : c0_wr;
    assign m_addr    = w_sel ? c1_addr  : c0_addr;
    assign m_wdata   = w_sel ? c1_wdata : c0_wdata;
    assign c0_ready  = w_push & ~w_sel;
    assign c1_ready  = w_push & w_sel;
    assign c0_rvalid = w_pop & ~w_head;
    assign c1_rvalid = w_pop & w_head;
    assign c0_rdata  = m_rdata;
    assign c1_rdata  = m_rdata;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) r_owner <= w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
                r_last           <= w_sel;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (m_rvalid & (r_count == '0)) r_err <= 1'b1;
            r_count <= r_count + (TAG_PTR_W+1)'(w_push) - (TAG_PTR_W+1)'(w_pop);
        end
    end
endmodule
